// File: rtl/hazard_ctrl_tnew.sv
// ============================================================================
// Module   : hazard_ctrl_tnew
// Brief    : Tuse/Tnew hazard, bypass-select and mult/div busy controller
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_tnew #(
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10,
  parameter int CW      = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [AW-1:0] d_wr,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [TW-1:0] d_tnew,
  input  logic          d_md_use,
  input  logic          d_md_start,
  input  logic          d_md_div,
  output logic          stall,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e,
  output logic          fwd_rt_m,
  output logic          md_busy
);

  localparam logic [CW-1:0] c_mul_cyc = CW'(MUL_CYC);
  localparam logic [CW-1:0] c_div_cyc = CW'(DIV_CYC);

  logic [AW-1:0] r_e_rs, r_e_rt, r_e_wr;
  logic [TW-1:0] r_e_tnew;
  logic          r_e_md_start, r_e_md_div;
  logic [AW-1:0] r_m_rt, r_m_wr;
  logic [TW-1:0] r_m_tnew;
  logic [AW-1:0] r_w_wr;
  logic [CW-1:0] r_md_cnt;

  logic w_stall_rs, w_stall_rt, w_stall_md;

  // Nearest producer decides; a not-yet-ready nearest producer blocks older ones.
  function automatic logic [1:0] f_fwd_d(
    input logic [AW-1:0] s,
    input logic [AW-1:0] e_wr,
    input logic [TW-1:0] e_tnew,
    input logic [AW-1:0] m_wr,
    input logic [TW-1:0] m_tnew,
    input logic [AW-1:0] w_wr
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (s != '0) begin
      if (e_wr == s)      sel = (e_tnew == '0) ? 2'd1 : 2'd0;
      else if (m_wr == s) sel = (m_tnew == '0) ? 2'd2 : 2'd0;
      else if (w_wr == s) sel = 2'd3;
    end
    return sel;
  endfunction

  function automatic logic [1:0] f_fwd_e(
    input logic [AW-1:0] s,
    input logic [AW-1:0] m_wr,
    input logic [TW-1:0] m_tnew,
    input logic [AW-1:0] w_wr
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (s != '0) begin
      if (m_wr == s && m_tnew == '0) sel = 2'd1;
      else if (w_wr == s)            sel = 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    w_stall_rs = (d_rs != '0) &&
                 ((r_e_wr == d_rs && r_e_tnew > d_tuse_rs) ||
                  (r_m_wr == d_rs && r_m_tnew > d_tuse_rs));
    w_stall_rt = (d_rt != '0) &&
                 ((r_e_wr == d_rt && r_e_tnew > d_tuse_rt) ||
                  (r_m_wr == d_rt && r_m_tnew > d_tuse_rt));
    md_busy    = (r_md_cnt != '0) || r_e_md_start;
    w_stall_md = d_md_use && md_busy;
    stall      = w_stall_rs || w_stall_rt || w_stall_md;
  end

  always_comb begin
    fwd_rs_d = f_fwd_d(d_rs, r_e_wr, r_e_tnew, r_m_wr, r_m_tnew, r_w_wr);
    fwd_rt_d = f_fwd_d(d_rt, r_e_wr, r_e_tnew, r_m_wr, r_m_tnew, r_w_wr);
    fwd_rs_e = f_fwd_e(r_e_rs, r_m_wr, r_m_tnew, r_w_wr);
    fwd_rt_e = f_fwd_e(r_e_rt, r_m_wr, r_m_tnew, r_w_wr);
    fwd_rt_m = (r_m_rt != '0) && (r_m_rt == r_w_wr);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_e_rs       <= '0;
      r_e_rt       <= '0;
      r_e_wr       <= '0;
      r_e_tnew     <= '0;
      r_e_md_start <= 1'b0;
      r_e_md_div   <= 1'b0;
      r_m_rt       <= '0;
      r_m_wr       <= '0;
      r_m_tnew     <= '0;
      r_w_wr       <= '0;
      r_md_cnt     <= '0;
    end else begin
      if (stall) begin
        r_e_rs       <= '0;
        r_e_rt       <= '0;
        r_e_wr       <= '0;
        r_e_tnew     <= '0;
        r_e_md_start <= 1'b0;
        r_e_md_div   <= 1'b0;
      end else begin
        r_e_rs       <= d_rs;
        r_e_rt       <= d_rt;
        r_e_wr       <= d_wr;
        r_e_tnew     <= d_tnew;
        r_e_md_start <= d_md_start;
        r_e_md_div   <= d_md_div;
      end
      r_m_rt   <= r_e_rt;
      r_m_wr   <= r_e_wr;
      r_m_tnew <= (r_e_tnew == '0) ? '0 : r_e_tnew - TW'(1);
      r_w_wr   <= r_m_wr;

      // The counter is loaded only while the op sits in E; md_busy covers that cycle.
      if (r_e_md_start)        r_md_cnt <= r_e_md_div ? c_div_cyc : c_mul_cyc;
      else if (r_md_cnt != '0) r_md_cnt <= r_md_cnt - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_tnew.sv
// ============================================================================
// Module   : tb_hazard_ctrl_tnew
// Brief    : Self-checking bench for hazard_ctrl_tnew (stage-list model + directed)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_tnew;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] d_rs, d_rt, d_wr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_use, d_md_start, d_md_div;
  logic       stall, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_ctrl_tnew dut (
    .Clk(Clk), .Reset(Reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_wr(d_wr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_tnew(d_tnew),
    .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .md_busy(md_busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: list of in-flight instructions, index 0=E, 1=M, 2=W; tnew counts down.
  typedef struct {
    int rs; int rt; int wr; int tnew; bit mds; bit mdd;
  } stage_t;

  stage_t st[3];
  int     md_left = 0;
  bit     armed   = 1'b0;

  function automatic bit m_src_stall(int s, int tuse);
    if (s == 0) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (st[i].wr == s && st[i].tnew > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    return (md_left > 0) || st[0].mds;
  endfunction

  function automatic bit m_stall();
    return m_src_stall(int'(d_rs), int'(d_tuse_rs)) ||
           m_src_stall(int'(d_rt), int'(d_tuse_rt)) ||
           (d_md_use && m_busy());
  endfunction

  function automatic int m_fwd_d(int s);
    if (s == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (st[i].wr == s) return (i == 2) ? 3 : ((st[i].tnew == 0) ? i + 1 : 0);
    return 0;
  endfunction

  function automatic int m_fwd_e(int s);
    if (s == 0) return 0;
    if (st[1].wr == s && st[1].tnew == 0) return 1;
    if (st[2].wr == s) return 2;
    return 0;
  endfunction

  always @(posedge Clk) begin
    bit stl;
    stl = m_stall();
    if (Reset) begin
      for (int i = 0; i < 3; i++) st[i] = '{default: 0};
      md_left = 0;
      armed   = 1'b1;
    end else begin
      if (st[0].mds)       md_left = st[0].mdd ? 10 : 5;
      else if (md_left > 0) md_left = md_left - 1;
      st[2] = st[1];
      st[1] = st[0];
      st[1].tnew = (st[0].tnew > 0) ? st[0].tnew - 1 : 0;
      if (stl) st[0] = '{default: 0};
      else st[0] = '{int'(d_rs), int'(d_rt), int'(d_wr), int'(d_tnew),
                     d_md_start, d_md_div};
    end
  end

  always @(negedge Clk) begin
    if (armed) begin
      check("cyc_stall",    int'(stall),    int'(m_stall()));
      check("cyc_md_busy",  int'(md_busy),  int'(m_busy()));
      check("cyc_fwd_rs_d", int'(fwd_rs_d), m_fwd_d(int'(d_rs)));
      check("cyc_fwd_rt_d", int'(fwd_rt_d), m_fwd_d(int'(d_rt)));
      check("cyc_fwd_rs_e", int'(fwd_rs_e), m_fwd_e(st[0].rs));
      check("cyc_fwd_rt_e", int'(fwd_rt_e), m_fwd_e(st[0].rt));
      check("cyc_fwd_rt_m", int'(fwd_rt_m),
            int'(st[1].rt != 0 && st[1].rt == st[2].wr));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic peek();
    #3;
  endtask

  task automatic set_d(input int rs, input int rt, input int wr,
                       input int tu_rs, input int tu_rt, input int tn,
                       input bit mu, input bit ms, input bit mdv);
    d_rs = 5'(rs); d_rt = 5'(rt); d_wr = 5'(wr);
    d_tuse_rs = 2'(tu_rs); d_tuse_rt = 2'(tu_rt); d_tnew = 2'(tn);
    d_md_use = mu; d_md_start = ms; d_md_div = mdv;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 3, 3, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  task automatic count_md_stall(input string name, input int exp);
    int n;
    n = 0;
    peek();
    while (stall && n < 40) begin
      n++;
      tick();
      peek();
    end
    check(name, n, exp);
  endtask

  initial begin
    Reset = 1'b1;
    nop();
    tick(); tick();
    Reset = 1'b0;
    peek();
    check("rst_stall", int'(stall), 0);
    check("rst_busy",  int'(md_busy), 0);
    check("rst_fwd_rs_e", int'(fwd_rs_e), 0);
    tick();

    // lw $1,0($2) then add $4,$1,$5
    set_d(2, 0, 1, 1, 3, 2, 0, 0, 0); peek();
    check("t1_lw_stall", int'(stall), 0);
    tick();
    set_d(1, 5, 4, 1, 1, 1, 0, 0, 0); peek();
    check("t1_stall1", int'(stall), 1);
    check("t1_fwd_d_blocked", int'(fwd_rs_d), 0);
    tick(); peek();
    check("t1_stall2", int'(stall), 0);
    tick(); nop(); peek();
    check("t1_fwd_rs_e_w", int'(fwd_rs_e), 2);
    drain();

    // addu $3 then beq $3,$0
    set_d(6, 7, 3, 1, 1, 1, 0, 0, 0); tick();
    set_d(3, 0, 0, 0, 3, 0, 0, 0, 0); peek();
    check("t2_stall", int'(stall), 1);
    tick(); peek();
    check("t2_stall_clr", int'(stall), 0);
    check("t2_fwd_rs_d_m", int'(fwd_rs_d), 2);
    drain();

    // jal then jr $31
    set_d(0, 0, 31, 3, 3, 0, 0, 0, 0); tick();
    set_d(31, 0, 0, 0, 3, 0, 0, 0, 0); peek();
    check("t3_stall", int'(stall), 0);
    check("t3_fwd_rs_d_e", int'(fwd_rs_d), 1);
    drain();

    // div then mflo; mult then mflo
    set_d(8, 9, 0, 1, 1, 0, 1, 1, 1); peek();
    check("t4_div_nostall", int'(stall), 0);
    tick();
    set_d(0, 0, 10, 3, 3, 1, 1, 0, 0); peek();
    check("t4_busy_first_e", int'(md_busy), 1);
    count_md_stall("t4_div_stall_cycles", 11);
    tick();
    set_d(8, 9, 0, 1, 1, 0, 1, 1, 0); tick();
    set_d(0, 0, 10, 3, 3, 1, 1, 0, 0);
    count_md_stall("t4_mul_stall_cycles", 6);
    drain();

    // writer to $0 then reader of $0
    set_d(1, 2, 0, 1, 1, 1, 0, 0, 0); tick();
    set_d(0, 0, 11, 0, 0, 1, 0, 0, 0); peek();
    check("t5_stall", int'(stall), 0);
    check("t5_fwd_rs_d", int'(fwd_rs_d), 0);
    check("t5_fwd_rt_d", int'(fwd_rt_d), 0);
    drain();

    // addu $3 then subu using $3 in E: M bypass
    set_d(6, 7, 3, 1, 1, 1, 0, 0, 0); tick();
    set_d(3, 0, 12, 1, 3, 1, 0, 0, 0); peek();
    check("t7_nostall", int'(stall), 0);
    tick(); nop(); peek();
    check("t7_fwd_rs_e_m", int'(fwd_rs_e), 1);
    drain();

    // addu $5 then sw $5: E then M store-data bypass
    set_d(6, 7, 5, 1, 1, 1, 0, 0, 0); tick();
    set_d(0, 5, 0, 3, 2, 0, 0, 0, 0); tick(); nop(); peek();
    check("t8_fwd_rt_e_m", int'(fwd_rt_e), 1);
    tick(); peek();
    check("t8_fwd_rt_m", int'(fwd_rt_m), 1);
    drain();

    // Reset while counter = 7 and lw in E
    set_d(8, 9, 0, 1, 1, 0, 1, 1, 1); tick();
    nop(); tick(); tick(); tick();
    set_d(2, 0, 1, 1, 3, 2, 0, 0, 0); tick();
    set_d(1, 0, 4, 1, 3, 1, 1, 0, 0); peek();
    check("t6_pre_busy", int'(md_busy), 1);
    check("t6_pre_stall", int'(stall), 1);
    Reset = 1'b1;
    tick(); peek();
    check("t6_stall", int'(stall), 0);
    check("t6_busy", int'(md_busy), 0);
    check("t6_fwd_rs_d", int'(fwd_rs_d), 0);
    check("t6_fwd_rs_e", int'(fwd_rs_e), 0);
    Reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
